matrix_op_sequencer: RTL
========================

# matrix_op_sequencer

Sequences one matrix operation end-to-end around the matrix storage block: it loads operands, validates dimensions, starts the compute engine, and streams the result matrix back into storage. It sits between the UI/command FSM and the storage and compute blocks. It executes at most one operation at a time and reports completion or a coded error.

## Interface
- TIMEOUT_CYCLES, 1023: maximum number of WAIT cycles for `alu_done` before an error is raised.
- MAX_MATRICES, 10: number of storage slots; valid IDs are 0..MAX_MATRICES-1.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- op_req  in  1  one-cycle command strobe.
- op_code  in  3  operation select: 0 ADD, 1 SUB, 2 SCALAR_MUL, 3 TRANSPOSE, 4 MUL; 5-7 are illegal.
- op_a_id, op_b_id  in  4  operand slot IDs; `op_b_id` is ignored for codes 2 and 3.
- load_operands  out  1  one-cycle pulse to storage.
- operand_a_id, operand_b_id  out  4  latched IDs sent to storage.
- a_m, a_n, b_m, b_n  in  3  operand dimensions returned by storage; 0 means an empty slot.
- alu_start  out  1  one-cycle pulse to the compute engine.
- alu_op  out  3  latched `op_code`.
- alu_done  in  1  compute-complete pulse.
- res_rd_idx  out  5  element index into the compute result buffer.
- res_rd_data  in  8  combinational read data from the compute result buffer.
- op_done  out  1  one-cycle pulse telling storage to begin a result write.
- result_data  out  8  result element stream to storage.
- res_m, res_n  out  3  result dimensions.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle success pulse.
- err  out  1  one-cycle error pulse.
- err_code  out  3  held error code: 0 none, 1 bad ID, 2 empty operand, 3 dimension mismatch, 4 timeout, 5 bad opcode.

## Operation
- States: IDLE, LOAD, CHECK, EXEC, WAIT, STORE_START, STREAM, DONE, ERR. All control outputs are Moore outputs decoded from a registered state.
- IDLE
  - On `op_req`, latch `op_code`, `op_a_id`, `op_b_id`, clear `err_code`, and go to LOAD.
  - `op_req` while `busy` is ignored; it is not queued.
- LOAD: `load_operands`=1 for exactly 1 cycle; go to CHECK. Operand dimensions are valid in the CHECK cycle.
- CHECK applies these checks in priority order; the first failure sets the code and goes to ERR:
  - opcode > 4 → 5.
  - a_id ≥ MAX_MATRICES, or b_id ≥ MAX_MATRICES on a two-operand op → 1.
  - a_m or a_n = 0, or b_m or b_n = 0 on a two-operand op → 2.
  - ADD/SUB requires a_m=b_m and a_n=b_n; MUL requires a_n=b_m; otherwise → 3.
- On a CHECK pass, register `res_m`/`res_n` and go to EXEC:
  - ADD, SUB, SCALAR_MUL: a_m × a_n.
  - TRANSPOSE: a_n × a_m.
  - MUL: a_m × b_n.
- EXEC: `alu_start`=1 for 1 cycle; clear the watchdog; go to WAIT.
- WAIT
  - On `alu_done`, go to STORE_START.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES, set code 4 and go to ERR.
- STORE_START: `op_done`=1 for 1 cycle; `res_rd_idx`=0; go to STREAM.
- STREAM
  - Runs for exactly N = res_m × res_n cycles (5-bit product, max 25).
  - In cycle k: `res_rd_idx`=k and `result_data`=`res_rd_data` (combinational pass-through).
  - After the cycle with k=N-1, go to DONE.
- DONE: `done`=1 for 1 cycle; go to IDLE.
- ERR: `err`=1 for 1 cycle; go to IDLE. `err_code` holds until the next accepted `op_req`.
- `alu_done` outside WAIT is ignored.
- `result_data`=0 outside STREAM.
- `res_m`/`res_n` hold their values until the next successful CHECK.

## Timing
- Reset values: state IDLE; every output 0, including `err_code` and `res_m`/`res_n`; watchdog 0.
- Reset asserted mid-operation aborts immediately; `op_done` is not issued afterwards.
- Latencies counted from the `op_req` cycle T:
  - `load_operands` is high in T+1.
  - CHECK is at T+2.
  - `alu_start` is high in T+3.
- From the `alu_done` cycle D:
  - `op_done` is high in D+1.
  - Element k is driven in cycle D+2+k.
  - `done` is high in D+2+N.
- The earliest error is at T+3: `err` high in that cycle, and `busy` low at T+4.
- `op_req` is accepted again in the first cycle `busy`=0.

## Test plan
- ADD, A=2×3, B=2×3, ALU done 4 cycles after start, `res_rd_data`=idx+1 → `op_done` once; `result_data` = 1..6 on 6 consecutive cycles; `res_m`=2, `res_n`=3; `done` 1 cycle; `err_code`=0.
- MUL, A=2×3, B=3×4 → `res_m`=2, `res_n`=4; 8 STREAM cycles. TRANSPOSE, A=5×1 → `res_m`=1, `res_n`=5; 5 STREAM cycles.
- Error coding:
  - ADD with 2×3 + 3×2 → `err` at T+3, `err_code`=3, no `alu_start`.
  - `op_a_id`=12 → code 1.
  - `a_m`=0 → code 2.
  - `op_code`=6 → code 5.
- TIMEOUT_CYCLES=8 with `alu_done` never asserted → `err_code`=4 exactly 8 cycles into WAIT; `op_done` never asserted.
- Second `op_req` pulse during WAIT → ignored: a single `done`, and latched IDs unchanged. `op_req` in the cycle after `done` → accepted.
- `rst_n` low during STREAM (k=3 of 9) → all outputs 0 asynchronously; after release, `busy`=0 and no further `op_done`/`done`.

Source files
------------

// File: rtl/matrix_op_sequencer_if.sv
// Signal bundle between the matrix op sequencer and its environment:
// the command source, matrix storage and the compute engine.
interface matrix_op_sequencer_if;
    logic       op_req;
    logic [2:0] op_code;
    logic [3:0] op_a_id;
    logic [3:0] op_b_id;
    logic       load_operands;
    logic [3:0] operand_a_id;
    logic [3:0] operand_b_id;
    logic [2:0] a_m;
    logic [2:0] a_n;
    logic [2:0] b_m;
    logic [2:0] b_n;
    logic       alu_start;
    logic [2:0] alu_op;
    logic       alu_done;
    logic [4:0] res_rd_idx;
    logic [7:0] res_rd_data;
    logic       op_done;
    logic [7:0] result_data;
    logic [2:0] res_m;
    logic [2:0] res_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] err_code;

    // Environment side: command source, storage and compute engine.
    modport master (
        output op_req, op_code, op_a_id, op_b_id,
        output a_m, a_n, b_m, b_n, alu_done, res_rd_data,
        input  load_operands, operand_a_id, operand_b_id, alu_start, alu_op,
        input  res_rd_idx, op_done, result_data, res_m, res_n,
        input  busy, done, err, err_code
    );

    // Sequencer side.
    modport slave (
        input  op_req, op_code, op_a_id, op_b_id,
        input  a_m, a_n, b_m, b_n, alu_done, res_rd_data,
        output load_operands, operand_a_id, operand_b_id, alu_start, alu_op,
        output res_rd_idx, op_done, result_data, res_m, res_n,
        output busy, done, err, err_code
    );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Runs one matrix operation end-to-end: load operands, validate, start the
// compute engine, wait with a watchdog, then stream the result to storage.
module matrix_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned MAX_MATRICES   = 10
) (
    input logic              clk,
    input logic              rst_n,
    matrix_op_sequencer_if.slave bus
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, CHECK, EXEC, WAIT, STORE_START, STREAM, DONE, ERR
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd4;

    state_t          state_q, state_d;
    logic [2:0]      op_code_q, op_code_d;
    logic [3:0]      a_id_q, a_id_d;
    logic [3:0]      b_id_q, b_id_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [2:0]      res_m_q, res_m_d;
    logic [2:0]      res_n_q, res_n_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [4:0]      idx_q, idx_d;
    logic            load_q, load_d;
    logic            start_q, start_d;
    logic            op_done_q, op_done_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            two_op;
    logic            bad_id;
    logic            empty;
    logic            mismatch;
    logic [WD_W-1:0] wd_inc;
    logic [4:0]      n_last;

    always_comb begin
        two_op   = (op_code_q == OP_ADD) || (op_code_q == OP_SUB) || (op_code_q == OP_MUL);
        bad_id   = (32'(a_id_q) >= MAX_MATRICES) || (two_op && (32'(b_id_q) >= MAX_MATRICES));
        empty    = (bus.a_m == '0) || (bus.a_n == '0) ||
                   (two_op && ((bus.b_m == '0) || (bus.b_n == '0)));
        mismatch = (((op_code_q == OP_ADD) || (op_code_q == OP_SUB)) &&
                    ((bus.a_m != bus.b_m) || (bus.a_n != bus.b_n))) ||
                   ((op_code_q == OP_MUL) && (bus.a_n != bus.b_m));
        wd_inc   = wd_q + WD_W'(1);
        // Element count wraps to 5 bits; largest legal result is 5x5.
        n_last   = ({2'b00, res_m_q} * {2'b00, res_n_q}) - 5'd1;
    end

    always_comb begin
        state_d    = state_q;
        op_code_d  = op_code_q;
        a_id_d     = a_id_q;
        b_id_d     = b_id_q;
        err_code_d = err_code_q;
        res_m_d    = res_m_q;
        res_n_d    = res_n_q;
        wd_d       = wd_q;
        idx_d      = idx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.op_req) begin
                    op_code_d  = bus.op_code;
                    a_id_d     = bus.op_a_id;
                    b_id_d     = bus.op_b_id;
                    err_code_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: state_d = CHECK;
            CHECK: begin
                if (op_code_q > 3'd4) begin
                    err_code_d = 3'd5;
                    state_d    = ERR;
                end else if (bad_id) begin
                    err_code_d = 3'd1;
                    state_d    = ERR;
                end else if (empty) begin
                    err_code_d = 3'd2;
                    state_d    = ERR;
                end else if (mismatch) begin
                    err_code_d = 3'd3;
                    state_d    = ERR;
                end else begin
                    unique case (op_code_q)
                        3'd3: begin res_m_d = bus.a_n; res_n_d = bus.a_m; end
                        3'd4: begin res_m_d = bus.a_m; res_n_d = bus.b_n; end
                        default: begin res_m_d = bus.a_m; res_n_d = bus.a_n; end
                    endcase
                    state_d = EXEC;
                end
            end
            EXEC: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.alu_done) begin
                    state_d = STORE_START;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
                        err_code_d = 3'd4;
                        state_d    = ERR;
                    end
                end
            end
            STORE_START: begin
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (idx_q == n_last) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pulses are registered from the next state so they line up with it.
        load_d    = (state_d == LOAD);
        start_d   = (state_d == EXEC);
        op_done_d = (state_d == STORE_START);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_code_q  <= '0;
            a_id_q     <= '0;
            b_id_q     <= '0;
            err_code_q <= '0;
            res_m_q    <= '0;
            res_n_q    <= '0;
            wd_q       <= '0;
            idx_q      <= '0;
            load_q     <= 1'b0;
            start_q    <= 1'b0;
            op_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_code_q  <= op_code_d;
            a_id_q     <= a_id_d;
            b_id_q     <= b_id_d;
            err_code_q <= err_code_d;
            res_m_q    <= res_m_d;
            res_n_q    <= res_n_d;
            wd_q       <= wd_d;
            idx_q      <= idx_d;
            load_q     <= load_d;
            start_q    <= start_d;
            op_done_q  <= op_done_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.load_operands = load_q;
    assign bus.operand_a_id  = a_id_q;
    assign bus.operand_b_id  = b_id_q;
    assign bus.alu_start     = start_q;
    assign bus.alu_op        = op_code_q;
    assign bus.res_rd_idx    = idx_q;
    assign bus.op_done       = op_done_q;
    assign bus.result_data   = (state_q == STREAM) ? bus.res_rd_data : '0;
    assign bus.res_m         = res_m_q;
    assign bus.res_n         = res_n_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.err_code      = err_code_q;

endmodule
